isdu_ctrl: RTL and testbench

//  SLC-3 instruction sequencing/decode unit: Moore FSM that drives every load, gate, mux-select
//  and memory-strobe control input of the SLC-3 datapath. Sits beside the datapath, fed by
//  IR/BEN status from it. Runs fetch -> decode -> execute, holding memory strobes for a

---
 rtl/isdu_ctrl.sv | 153 +++++++++++++++
 tb/tb_isdu_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/isdu_ctrl.sv
// rtl/isdu_ctrl.sv - SLC-3 instruction sequencing/decode Moore FSM driving the datapath controls.
// Defining SLC3_PAUSE_EN adds the PAUSE opcode (1101) states PauseIR1/PauseIR2 and drives LD_LED.
module isdu_ctrl #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, S_18, S_33, S_35, S_32, S_01, S_05, S_09, S_00, S_22,
        S_12, S_04, S_21, S_06, S_25, S_27, S_07, S_23, S_16
`ifdef SLC3_PAUSE_EN
        , PAUSE_IR1, PAUSE_IR2
`endif
    } state_t;

    state_t     state, state_next;
    logic [2:0] wait_cnt;
    logic       wait_done;
    logic       in_wait;

    assign wait_done = (wait_cnt == 3'(MEM_WAIT - 1));
    assign in_wait   = (state == S_33) || (state == S_25) || (state == S_16);

    // Counter restarts whenever a wait state is entered and counts while it is held.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= HALTED;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= (in_wait && state_next == state) ? wait_cnt + 3'd1 : 3'd0;
        end
    end

`ifdef SLC3_PAUSE_EN
    logic led_first;

    // LD_LED pulses only on the first cycle of PauseIR1, however long it is held there.
    always_ff @(posedge Clk) begin
        if (!Reset) led_first <= 1'b0;
        else        led_first <= (state_next == PAUSE_IR1) && (state != PAUSE_IR1);
    end
`else
    wire unused_continue = Continue;
`endif

    always_comb begin
        state_next = state;
        case (state)
            HALTED: if (Run) state_next = S_18;
            S_18:   state_next = S_33;
            S_33:   if (wait_done) state_next = S_35;
            S_35:   state_next = S_32;
            S_32: begin
                case (Opcode)
                    4'b0001: state_next = S_01;
                    4'b0101: state_next = S_05;
                    4'b1001: state_next = S_09;
                    4'b0000: state_next = S_00;
                    4'b1100: state_next = S_12;
                    4'b0100: state_next = S_04;
                    4'b0110: state_next = S_06;
                    4'b0111: state_next = S_07;
`ifdef SLC3_PAUSE_EN
                    4'b1101: state_next = PAUSE_IR1;
`endif
                    default: state_next = S_18;
                endcase
            end
            S_00:   state_next = BEN ? S_22 : S_18;
            S_04:   state_next = S_21;
            S_06:   state_next = S_25;
            S_25:   if (wait_done) state_next = S_27;
            S_07:   state_next = S_23;
            S_23:   state_next = S_16;
            S_16:   if (wait_done) state_next = S_18;
`ifdef SLC3_PAUSE_EN
            PAUSE_IR1: if (Continue)  state_next = PAUSE_IR2;
            PAUSE_IR2: if (!Continue) state_next = S_18;
`endif
            default: state_next = S_18;
        endcase
    end

    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; ALUK = 2'b00;
        Mem_OE = 1'b1; Mem_WE = 1'b1;
        case (state)
            S_18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
            S_33, S_25: begin Mem_OE = 1'b0; LD_MDR = wait_done; end
            S_35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
            S_32: LD_BEN = 1'b1;
            S_01, S_05, S_09: begin
                SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                ALUK = (state == S_01) ? 2'b00 : (state == S_05) ? 2'b01 : 2'b10;
                SR2MUX = (state == S_09) ? 1'b0 : IR_5;
            end
            S_22: begin ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1; end
            S_12: begin SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; end
            S_04: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
            S_21: begin
                if (IR_11) ADDR2MUX = 2'b11;
                else begin SR1MUX = 1'b1; ADDR1MUX = 1'b1; end
                PCMUX = 2'b10; LD_PC = 1'b1;
            end
            S_06, S_07: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
            end
            S_27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
            S_23: begin ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
            S_16: Mem_WE = 1'b0;
`ifdef SLC3_PAUSE_EN
            PAUSE_IR1: LD_LED = led_first;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_isdu_ctrl.sv
// tb/tb_isdu_ctrl.sv - table-driven scoreboard bench for isdu_ctrl at MEM_WAIT=2 and MEM_WAIT=3.
module tb_isdu_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'b0000;
    logic       IR_5 = 1'b0;
    logic       IR_11 = 1'b0;
    logic       BEN = 1'b0;
    wire [23:0] obs2, obs3;

    always #5 Clk = ~Clk;

    isdu_ctrl #(.MEM_WAIT(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(obs2[23]), .LD_MDR(obs2[22]), .LD_IR(obs2[21]), .LD_BEN(obs2[20]),
        .LD_CC(obs2[19]), .LD_REG(obs2[18]), .LD_PC(obs2[17]), .LD_LED(obs2[16]),
        .GatePC(obs2[15]), .GateMDR(obs2[14]), .GateALU(obs2[13]), .GateMARMUX(obs2[12]),
        .PCMUX(obs2[11:10]), .DRMUX(obs2[9]), .SR1MUX(obs2[8]), .SR2MUX(obs2[7]),
        .ADDR1MUX(obs2[6]), .ADDR2MUX(obs2[5:4]), .ALUK(obs2[3:2]),
        .Mem_OE(obs2[1]), .Mem_WE(obs2[0])
    );

    isdu_ctrl #(.MEM_WAIT(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(obs3[23]), .LD_MDR(obs3[22]), .LD_IR(obs3[21]), .LD_BEN(obs3[20]),
        .LD_CC(obs3[19]), .LD_REG(obs3[18]), .LD_PC(obs3[17]), .LD_LED(obs3[16]),
        .GatePC(obs3[15]), .GateMDR(obs3[14]), .GateALU(obs3[13]), .GateMARMUX(obs3[12]),
        .PCMUX(obs3[11:10]), .DRMUX(obs3[9]), .SR1MUX(obs3[8]), .SR2MUX(obs3[7]),
        .ADDR1MUX(obs3[6]), .ADDR2MUX(obs3[5:4]), .ALUK(obs3[3:2]),
        .Mem_OE(obs3[1]), .Mem_WE(obs3[0])
    );

    // Control words: {LD_MAR,LD_MDR,LD_IR,LD_BEN,LD_CC,LD_REG,LD_PC,LD_LED,
    //  GatePC,GateMDR,GateALU,GateMARMUX,PCMUX[2],DRMUX,SR1MUX,SR2MUX,ADDR1MUX,ADDR2MUX[2],ALUK[2],OE,WE}
    localparam logic [23:0] W_IDLE   = 24'h000003;
    localparam logic [23:0] W_S18    = 24'h828003;
    localparam logic [23:0] W_RD     = 24'h000001;
    localparam logic [23:0] W_RDLAST = 24'h400001;
    localparam logic [23:0] W_S35    = 24'h204003;
    localparam logic [23:0] W_S32    = 24'h100003;
    localparam logic [23:0] W_S22    = 24'h020823;
    localparam logic [23:0] W_S12    = 24'h020943;
    localparam logic [23:0] W_S04    = 24'h048203;
    localparam logic [23:0] W_S21J   = 24'h020833;
    localparam logic [23:0] W_ADDR   = 24'h801153;
    localparam logic [23:0] W_S27    = 24'h0C4003;
    localparam logic [23:0] W_S23    = 24'h40200F;
    localparam logic [23:0] W_WR     = 24'h000002;
    localparam logic [23:0] W_LED    = 24'h010003;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        ir5;
        logic        ir11;
        logic        ben;
        int          n_pre;
        logic [23:0] pre0;
        logic [23:0] pre1;
        int          mem;       // 0 none, 1 read, 2 write
        logic        post_en;
        logic [23:0] post;
    } vec_t;

    vec_t        tbl[$];
    logic [23:0] q2[$];
    logic [23:0] q3[$];
    int          passed = 0;
    int          total = 0;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input int which, input logic [23:0] w);
        if (which == 2) q2.push_back(w);
        else q3.push_back(w);
    endtask

    task automatic push_fetch(input int which);
        push(which, W_S18);
        for (int i = 0; i < which - 1; i++) push(which, W_RD);
        push(which, W_RDLAST);
        push(which, W_S35);
        push(which, W_S32);
    endtask

    task automatic push_seq(input int which, input vec_t v);
        push_fetch(which);
        if (v.n_pre > 0) push(which, v.pre0);
        if (v.n_pre > 1) push(which, v.pre1);
        if (v.mem == 1) begin
            for (int i = 0; i < which - 1; i++) push(which, W_RD);
            push(which, W_RDLAST);
        end else if (v.mem == 2) begin
            for (int i = 0; i < which; i++) push(which, W_WR);
        end
        if (v.post_en) push(which, v.post);
        push(which, W_S18);
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while ((q2.size() > 0 || q3.size() > 0) && guard < 60) begin
            @(negedge Clk);
            guard++;
            if (q2.size() > 0) chk({name, "/w2"}, obs2, q2.pop_front());
            if (q3.size() > 0) chk({name, "/w3"}, obs3, q3.pop_front());
        end
        if (q2.size() > 0 || q3.size() > 0) begin
            total++;
            $display("FAIL %s timeout: %0d/%0d words left, expected 0", name, q2.size(), q3.size());
            q2.delete();
            q3.delete();
        end
    endtask

    // One reset edge from whatever state the DUTs are in, then check Halted outputs.
    task automatic do_reset(input string name);
        @(negedge Clk);
        Reset = 1'b0;
        Run = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        chk({name, "/rst_w2"}, obs2, W_IDLE);
        chk({name, "/rst_w3"}, obs3, W_IDLE);
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic ir5,
                           input logic ir11, input logic ben, input int n_pre,
                           input logic [23:0] pre0, input logic [23:0] pre1, input int mem,
                           input logic post_en, input logic [23:0] post);
        vec_t v;
        v.name = name; v.op = op; v.ir5 = ir5; v.ir11 = ir11; v.ben = ben;
        v.n_pre = n_pre; v.pre0 = pre0; v.pre1 = pre1; v.mem = mem;
        v.post_en = post_en; v.post = post;
        tbl.push_back(v);
    endtask

    initial begin
        add_vec("add_imm",  4'b0001, 1, 0, 0, 1, 24'h0C2183, 0, 0, 0, 0);
        add_vec("add_reg",  4'b0001, 0, 0, 0, 1, 24'h0C2103, 0, 0, 0, 0);
        add_vec("and_imm",  4'b0101, 1, 0, 0, 1, 24'h0C2187, 0, 0, 0, 0);
        add_vec("not",      4'b1001, 1, 0, 0, 1, 24'h0C210B, 0, 0, 0, 0);
        add_vec("br_nt",    4'b0000, 0, 0, 0, 1, W_IDLE, 0, 0, 0, 0);
        add_vec("br_t",     4'b0000, 0, 0, 1, 2, W_IDLE, W_S22, 0, 0, 0);
        add_vec("jmp",      4'b1100, 0, 0, 0, 1, W_S12, 0, 0, 0, 0);
        add_vec("jsrr",     4'b0100, 0, 0, 0, 2, W_S04, W_S12, 0, 0, 0);
        add_vec("jsr",      4'b0100, 0, 1, 0, 2, W_S04, W_S21J, 0, 0, 0);
        add_vec("ldr",      4'b0110, 0, 0, 0, 1, W_ADDR, 0, 1, 1, W_S27);
        add_vec("str",      4'b0111, 0, 0, 0, 2, W_ADDR, W_S23, 2, 0, 0);
        add_vec("nop_1111", 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifndef SLC3_PAUSE_EN
        add_vec("nop_1101", 4'b1101, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        do_reset("init");
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("halt_norun_w2", obs2, W_IDLE);
            chk("halt_norun_w3", obs3, W_IDLE);
        end

        // Each reset lands mid-fetch of the following instruction, exercising the abort path.
        foreach (tbl[k]) begin
            do_reset(tbl[k].name);
            Opcode = tbl[k].op;
            IR_5 = tbl[k].ir5;
            IR_11 = tbl[k].ir11;
            BEN = tbl[k].ben;
            Continue = 1'b1;
            Run = 1'b1;
            push_seq(2, tbl[k]);
            push_seq(3, tbl[k]);
            drain(tbl[k].name);
        end

`ifdef SLC3_PAUSE_EN
        do_reset("pause");
        Opcode = 4'b1101;
        Continue = 1'b0;
        Run = 1'b1;
        push_fetch(2);
        push(2, W_LED);
        drain("pause_entry");
        @(negedge Clk) chk("pause_hold1", obs2, W_IDLE);
        @(negedge Clk) chk("pause_hold2", obs2, W_IDLE);
        Continue = 1'b1;
        @(negedge Clk) chk("pause_ir2", obs2, W_IDLE);
        @(negedge Clk) chk("pause_ir2_hold", obs2, W_IDLE);
        Continue = 1'b0;
        @(negedge Clk) chk("pause_release", obs2, W_S18);
`endif

        do_reset("final");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
